// File: rtl/piso_pkg.sv
// piso_pkg: shared state encoding and counter-width helper for the PISO serializer
package piso_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction
endpackage

// File: rtl/piso_bit_counter.sv
// piso_bit_counter: frame bit down-counter (clk, rst_n, load restarts at WIDTH-1, en steps, last flags the final bit)
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic last
);
  localparam int CW = cnt_width(WIDTH);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt  <= '0;
      last <= 1'b0;
    end else if (load) begin
      cnt  <= CW'(WIDTH - 1);
      last <= 1'b0;
    end else if (en) begin
      cnt  <= cnt - CW'(1);
      last <= cnt == CW'(1);
    end
endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready WIDTH-bit parallel-in serial-out (in_valid/in_ready/in_data -> ser_out/ser_valid/frame_start/frame_done/busy; clk, async rst_n); define PISO_PARITY_EN to append an even-parity bit
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             frame_done,
  output logic             busy
);
  state_t state;
  logic [WIDTH-1:0] sr;
  logic last;
  logic hs;
`ifdef PISO_PARITY_EN
  logic par;
  assign in_ready   = state == IDLE || state == PARITY;
  assign frame_done = state == PARITY;
`else
  assign in_ready   = state == IDLE || (state == SHIFT && last);
  assign frame_done = state == SHIFT && last;
`endif
  assign hs   = in_valid && in_ready;
  assign busy = ser_valid;
  piso_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .load (hs),
    .en   (state == SHIFT && !last),
    .last (last)
  );
  // The first bit is driven straight from in_data so it appears the cycle after the handshake;
  // sr holds the remaining bits, already shifted by one.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      sr          <= '0;
      ser_out     <= IDLE_LEVEL;
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
`ifdef PISO_PARITY_EN
      par         <= 1'b0;
`endif
    end else begin
      frame_start <= hs;
      if (hs) begin
        state     <= SHIFT;
        ser_out   <= MSB_FIRST ? in_data[WIDTH-1] : in_data[0];
        sr        <= MSB_FIRST ? in_data << 1 : in_data >> 1;
        ser_valid <= 1'b1;
`ifdef PISO_PARITY_EN
        par       <= ^in_data;
`endif
      end else if (state == SHIFT && !last) begin
        ser_out <= MSB_FIRST ? sr[WIDTH-1] : sr[0];
        sr      <= MSB_FIRST ? sr << 1 : sr >> 1;
`ifdef PISO_PARITY_EN
      end else if (state == SHIFT) begin
        state   <= PARITY;
        ser_out <= par;
`endif
      end else begin
        state     <= IDLE;
        ser_out   <= IDLE_LEVEL;
        ser_valid <= 1'b0;
      end
    end
endmodule
